// File: rtl/sll_pkg.sv
// Shared types and constants for the sequential logical-left shifter.
// The helper maps the stage counter to that stage's shift distance.
package sll_pkg;

    localparam int WIDTH   = 32;
    localparam int AMT_W   = $clog2(WIDTH);
    localparam int NSTAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_t;

    function automatic logic [AMT_W-1:0] stage_dist(input logic [2:0] step);
        case (step)
            3'd0:    return 5'd16;
            3'd1:    return 5'd8;
            3'd2:    return 5'd4;
            3'd3:    return 5'd2;
            3'd4:    return 5'd1;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/sll_stage.sv
// One conditional left-shift stage with zero fill.
// The shift distance is an input, so the same mux is reused for every step.
module sll_stage
    import sll_pkg::*;
(
    input  logic [WIDTH-1:0] in_stage,
    input  logic             sel_stage,
    input  logic [AMT_W-1:0] sh_stage,
    output logic [WIDTH-1:0] out_stage
);

    // Pass through, or shift by the distance of the current step.
    always_comb begin
        out_stage = in_stage;
        if (sel_stage) begin
            out_stage = in_stage << sh_stage;
        end else begin
            out_stage = in_stage;
        end
    end

endmodule

// File: rtl/sll_seq.sv
// Sequential 32-bit logical-left shifter: five 16/8/4/2/1 stages, one per clock,
// behind a start/busy/done handshake with a fixed five-cycle latency.
module sll_seq
    import sll_pkg::*;
(
    input  logic             clk_sll,
    input  logic             rstn_sll,
    input  logic             start_sll,
    input  logic [WIDTH-1:0] in_sll,
    input  logic [AMT_W-1:0] amt_sll,
    output logic             busy_sll,
    output logic             done_sll,
    output logic [WIDTH-1:0] out_sll
);

    sll_state_t       state_r;
    logic [WIDTH-1:0] work_r;
    logic [AMT_W-1:0] amt_r;
    logic [2:0]       step_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] out_r;

    logic             stage_sel_s;
    logic [AMT_W-1:0] stage_sh_s;
    logic [WIDTH-1:0] stage_out_s;

    // Step k consumes amount bit 4-k, largest distance first.
    always_comb begin
        stage_sh_s  = stage_dist(step_r);
        stage_sel_s = 1'b0;
        case (step_r)
            3'd0:    stage_sel_s = amt_r[4];
            3'd1:    stage_sel_s = amt_r[3];
            3'd2:    stage_sel_s = amt_r[2];
            3'd3:    stage_sel_s = amt_r[1];
            3'd4:    stage_sel_s = amt_r[0];
            default: stage_sel_s = 1'b0;
        endcase
    end

    sll_stage u_stage (
        .in_stage  (work_r),
        .sel_stage (stage_sel_s),
        .sh_stage  (stage_sh_s),
        .out_stage (stage_out_s)
    );

    // Handshake FSM and datapath registers; DONE accepts a new start for back-to-back ops.
    always_ff @(posedge clk_sll or negedge rstn_sll) begin
        if (!rstn_sll) begin
            state_r <= IDLE;
            work_r  <= {WIDTH{1'b0}};
            amt_r   <= {AMT_W{1'b0}};
            step_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            out_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start_sll) begin
                        work_r  <= in_sll;
                        amt_r   <= amt_sll;
                        step_r  <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    work_r <= stage_out_s;
                    if (step_r == 3'(NSTAGES - 1)) begin
                        out_r   <= stage_out_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        step_r  <= 3'd0;
                        state_r <= DONE;
                    end else begin
                        step_r  <= step_r + 3'd1;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    step_r  <= 3'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_sll = busy_r;
    assign done_sll = done_r;
    assign out_sll  = out_r;

endmodule
